// File: rtl/z80_resp_pkg.sv
// Shared types and constants for the Z80 bus responder.
// Holds the access FSM state type, the I/O register offsets and the
// status register bit positions, plus the strobe decoder used by the FSM.
package z80_resp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        MEM_RD = 3'd1,
        MEM_WR = 3'd2,
        IO_RD  = 3'd3,
        IO_WR  = 3'd4,
        ERR    = 3'd5
    } resp_state_t;

    // Register offsets relative to IO_BASE (decoded on A[7:0])
    localparam logic [7:0] IO_STATUS_OFS = 8'd0;
    localparam logic [7:0] IO_DATA_OFS   = 8'd1;

    // Status register bit positions
    localparam int unsigned ST_RX_NE    = 0;
    localparam int unsigned ST_TX_NF    = 1;
    localparam int unsigned ST_TX_EMPTY = 2;
    localparam int unsigned ST_TX_OVR   = 3;
    localparam int unsigned ST_RX_UND   = 4;

    // Classify the current strobe pattern (active-high inputs).
    // Illegal combinations map to ERR, no recognised access maps to IDLE.
    function automatic resp_state_t decode_access(input logic mreq, input logic iorq,
                                                  input logic rd, input logic wr);
        resp_state_t kind;
        kind = IDLE;
        if ((mreq && iorq) || (rd && wr)) begin
            kind = ERR;
        end else if (mreq && rd) begin
            kind = MEM_RD;
        end else if (mreq && wr) begin
            kind = MEM_WR;
        end else if (iorq && rd) begin
            kind = IO_RD;
        end else if (iorq && wr) begin
            kind = IO_WR;
        end
        return kind;
    endfunction

endpackage

// File: rtl/z80_resp_fifo.sv
// Synchronous byte FIFO used for the responder's TX and RX streams.
// Pointers carry an index plus a wrap bit; full when indices match and the
// wrap bits differ. A pop at full frees the slot that a same-cycle push uses.
module z80_resp_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             CLK,
    input  logic             nRESET,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW:0] PTR_ONE = 1;

    logic [IW:0]      wr_ptr;
    logic [IW:0]      rd_ptr;
    logic [WIDTH-1:0] store [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[IW] != rd_ptr[IW]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = store[rd_ptr[IW-1:0]];

    // Pointer update; occupancy is derived from these registers only
    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge CLK) begin
        if (do_push) begin
            store[wr_ptr[IW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/z80_bus_responder.sv
// Z80 external bus target: aliased RAM plus a status/data I/O port pair
// backed by TX and RX byte FIFOs. Reads are combinational from the strobes;
// writes commit once on entry to the write state; RX pops on read release.
// Optional macro Z80_RESP_ROM_PROTECT_EN: memory writes below ROM_BYTES are
// discarded and flag bus_err.
module z80_bus_responder
  import z80_resp_pkg::*;
#(
  parameter int unsigned MEM_AW     = 12,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [7:0]  IO_BASE    = 8'h00,
  parameter int unsigned ROM_BYTES  = 256,
  parameter string       INIT_FILE  = ""
) (
  input  logic        CLK,
  input  logic        nRESET,
  input  logic [15:0] A,
  input  logic [7:0]  WRITE_D,
  input  logic        nMREQ,
  input  logic        nIORQ,
  input  logic        nRD,
  input  logic        nWR,
  output logic [7:0]  READ_D,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        bus_err
);

`ifdef Z80_RESP_ROM_PROTECT_EN
  localparam bit ROM_PROTECT = 1'b1;
`else
  localparam bit ROM_PROTECT = 1'b0;
`endif

  logic mreq, iorq, rd, wr;
  assign mreq = !nMREQ;
  assign iorq = !nIORQ;
  assign rd   = !nRD;
  assign wr   = !nWR;

  resp_state_t state, state_next, acc;
  assign acc = decode_access(mreq, iorq, rd, wr);

  // Address decode
  logic [7:0]        port_ofs;
  logic              is_status, is_data, in_rom;
  logic [MEM_AW-1:0] mem_idx;
  assign port_ofs  = A[7:0] - IO_BASE;
  assign is_status = (port_ofs == IO_STATUS_OFS);
  assign is_data   = (port_ofs == IO_DATA_OFS);
  assign in_rom    = (32'(A) < ROM_BYTES);
  assign mem_idx   = A[MEM_AW-1:0];

  logic [7:0] mem [0:(1 << MEM_AW)-1];

  // FIFO interfaces
  logic       tx_push, tx_pop, tx_full, tx_empty;
  logic       rx_push, rx_pop, rx_full, rx_empty;
  logic [7:0] tx_dout, rx_dout;

  // Sticky and per-access state
  logic tx_ovr, rx_und, bus_err_q, rx_pop_pending;

  // FSM side-effect strobes
  logic mem_we, ovr_set, ovr_clr, und_set, und_clr, pend_set, err_set;

  assign tx_valid = !tx_empty;
  assign tx_data  = tx_dout;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_ready = !rx_full;
  assign rx_push  = rx_valid && rx_ready;
  assign bus_err  = bus_err_q;

  // Next state and the one-shot side effects of each access
  always_comb begin
    state_next = state;
    mem_we     = 1'b0;
    tx_push    = 1'b0;
    rx_pop     = 1'b0;
    ovr_set    = 1'b0;
    ovr_clr    = 1'b0;
    und_set    = 1'b0;
    und_clr    = 1'b0;
    pend_set   = 1'b0;
    err_set    = 1'b0;
    case (state)
      IDLE: begin
        state_next = acc;
        case (acc)
          MEM_WR: begin
            if (ROM_PROTECT && in_rom) begin
              err_set = 1'b1;
            end else begin
              mem_we = 1'b1;
            end
          end
          IO_WR: begin
            if (is_data) begin
              if (tx_full) begin
                ovr_set = 1'b1;
              end else begin
                tx_push = 1'b1;
              end
            end else if (is_status) begin
              ovr_clr = WRITE_D[ST_TX_OVR];
              und_clr = WRITE_D[ST_RX_UND];
            end
          end
          IO_RD: begin
            // Head is checked on entry; the pop itself waits for release
            if (is_data) begin
              if (rx_empty) begin
                und_set = 1'b1;
              end else begin
                pend_set = 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
      MEM_RD, MEM_WR, IO_RD, IO_WR: begin
        if (!rd && !wr) begin
          state_next = IDLE;
          rx_pop     = (state == IO_RD) && rx_pop_pending;
        end else if (acc != state) begin
          state_next = ERR;
        end
      end
      ERR: begin
        if (!mreq && !iorq && !rd && !wr) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (state_next == ERR) begin
      err_set = 1'b1;
    end
  end

  // State register, sticky flags and the pending-pop marker
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state          <= IDLE;
      tx_ovr         <= 1'b0;
      rx_und         <= 1'b0;
      bus_err_q      <= 1'b0;
      rx_pop_pending <= 1'b0;
    end else begin
      state <= state_next;
      if (ovr_set) begin
        tx_ovr <= 1'b1;
      end else if (ovr_clr) begin
        tx_ovr <= 1'b0;
      end
      if (und_set) begin
        rx_und <= 1'b1;
      end else if (und_clr) begin
        rx_und <= 1'b0;
      end
      if (err_set) begin
        bus_err_q <= 1'b1;
      end
      rx_pop_pending <= (state_next == IO_RD) && (pend_set || rx_pop_pending);
    end
  end

  // RAM write port, once per write access
  always_ff @(posedge CLK) begin
    if (mem_we) begin
      mem[mem_idx] <= WRITE_D;
    end
  end

  // Combinational read data; 8'hFF unless a legal read is in progress
  logic [7:0] status;
  logic [7:0] io_rdata;
  logic       rx_head_ok;
  always_comb begin
    status              = '0;
    status[ST_RX_NE]    = !rx_empty;
    status[ST_TX_NF]    = !tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_TX_OVR]   = tx_ovr;
    status[ST_RX_UND]   = rx_und;

    // Within the strobe, the entry decision keeps data-port reads stable
    rx_head_ok = (state == IDLE) ? !rx_empty : rx_pop_pending;
    io_rdata   = '1;
    if (is_status) begin
      io_rdata = status;
    end else if (is_data) begin
      io_rdata = rx_head_ok ? rx_dout : 8'h00;
    end

    READ_D = '1;
    if (acc == MEM_RD && (state == IDLE || state == MEM_RD)) begin
      READ_D = mem[mem_idx];
    end else if (acc == IO_RD && (state == IDLE || state == IO_RD)) begin
      READ_D = io_rdata;
    end
  end

  z80_resp_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .CLK    (CLK),
    .nRESET (nRESET),
    .push   (tx_push),
    .pop    (tx_pop),
    .din    (WRITE_D),
    .dout   (tx_dout),
    .full   (tx_full),
    .empty  (tx_empty)
  );

  z80_resp_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .CLK    (CLK),
    .nRESET (nRESET),
    .push   (rx_push),
    .pop    (rx_pop),
    .din    (rx_data),
    .dout   (rx_dout),
    .full   (rx_full),
    .empty  (rx_empty)
  );

endmodule

// File: tb/tb_z80_bus_responder.sv
// Scoreboard bench for z80_bus_responder: driver tasks update a transaction
// level model and queue expected read bytes; a monitor compares READ_D on
// every sampled read-strobe cycle and tx_data on every TX handshake.
module tb_z80_bus_responder;

    localparam int unsigned MEM_AW    = 12;
    localparam int unsigned DEPTH     = 8;
    localparam int unsigned ROM_BYTES = 256;
    localparam logic [7:0]  IO_BASE   = 8'h10;
    localparam int unsigned MASK      = (1 << MEM_AW) - 1;
`ifdef Z80_RESP_ROM_PROTECT_EN
    localparam bit ROM_ON = 1'b1;
`else
    localparam bit ROM_ON = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        nRESET;
    logic [15:0] A;
    logic [7:0]  WRITE_D;
    logic        nMREQ, nIORQ, nRD, nWR;
    logic [7:0]  READ_D;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        bus_err;

    z80_bus_responder #(
        .MEM_AW     (MEM_AW),
        .FIFO_DEPTH (DEPTH),
        .IO_BASE    (IO_BASE),
        .ROM_BYTES  (ROM_BYTES),
        .INIT_FILE  ("")
    ) dut (
        .CLK      (CLK),
        .nRESET   (nRESET),
        .A        (A),
        .WRITE_D  (WRITE_D),
        .nMREQ    (nMREQ),
        .nIORQ    (nIORQ),
        .nRD      (nRD),
        .nWR      (nWR),
        .READ_D   (READ_D),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .bus_err  (bus_err)
    );

    always #5 CLK = ~CLK;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Reference model
    logic [7:0] rd_exp[$];
    logic [7:0] rx_m[$];
    logic [7:0] tx_m[$];
    logic [7:0] mem_m[int unsigned];
    int unsigned keys[$];
    bit ovr_m = 1'b0, und_m = 1'b0, err_m = 1'b0;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s at %0t", name, $time);
    endfunction

    function automatic logic [7:0] status_m();
        return {3'b000, und_m, ovr_m, tx_m.size() == 0, tx_m.size() < DEPTH, rx_m.size() != 0};
    endfunction

    function automatic logic [15:0] io_addr(input logic [7:0] ofs);
        logic [7:0] hi;
        hi = 8'($urandom);
        return {hi, 8'(IO_BASE + ofs)};
    endfunction

    // Monitor: compare every sampled output event against the queues
    always @(negedge CLK) begin
        if (nRESET) begin
            if (!nRD) begin
                if (rd_exp.size() == 0) fail_now("read_unexpected");
                else chk("read_data", READ_D, rd_exp.pop_front());
            end
            if (tx_valid && tx_ready) begin
                if (tx_m.size() == 0) fail_now("tx_unexpected");
                else chk("tx_data", tx_data, tx_m.pop_front());
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    // Drive one bus access of n strobe cycles, then release for one cycle
    task automatic strobe(input bit io, input bit wr, input logic [15:0] addr,
                          input logic [7:0] d, input int unsigned n);
        A = addr; WRITE_D = d;
        nMREQ = io; nIORQ = !io; nRD = wr; nWR = !wr;
        repeat (n) @(posedge CLK);
        #1;
        nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic mem_wr(input logic [15:0] addr, input logic [7:0] d, input int unsigned n);
        if (ROM_ON && addr < ROM_BYTES) begin
            err_m = 1'b1;
        end else begin
            if (!mem_m.exists(int'(addr) & MASK)) keys.push_back(int'(addr) & MASK);
            mem_m[int'(addr) & MASK] = d;
        end
        strobe(1'b0, 1'b1, addr, d, n);
    endtask

    task automatic mem_rd(input logic [15:0] addr, input int unsigned n);
        repeat (n) rd_exp.push_back(mem_m[int'(addr) & MASK]);
        strobe(1'b0, 1'b0, addr, 8'h00, n);
    endtask

    task automatic io_wr(input logic [7:0] ofs, input logic [7:0] d, input int unsigned n);
        if (ofs == 8'd1) begin
            if (tx_m.size() < DEPTH) tx_m.push_back(d);
            else ovr_m = 1'b1;
        end else if (ofs == 8'd0) begin
            if (d[3]) ovr_m = 1'b0;
            if (d[4]) und_m = 1'b0;
        end
        strobe(1'b1, 1'b1, io_addr(ofs), d, n);
    endtask

    task automatic io_rd(input logic [7:0] ofs, input int unsigned n);
        logic [7:0] e;
        if (ofs == 8'd0) begin
            e = status_m();
        end else if (ofs == 8'd1) begin
            if (rx_m.size() != 0) e = rx_m.pop_front();
            else begin e = 8'h00; und_m = 1'b1; end
        end else begin
            e = 8'hFF;
        end
        repeat (n) rd_exp.push_back(e);
        strobe(1'b1, 1'b0, io_addr(ofs), 8'h00, n);
    endtask

    task automatic rx_push(input logic [7:0] b);
        bit acc;
        acc = (rx_m.size() < DEPTH);
        chk("rx_ready", 8'(rx_ready), 8'(acc));
        rx_data = b; rx_valid = 1'b1;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        if (acc) rx_m.push_back(b);
    endtask

    task automatic tx_pop();
        chk("tx_valid", 8'(tx_valid), 8'(tx_m.size() != 0));
        tx_ready = 1'b1;
        @(posedge CLK); #1;
        tx_ready = 1'b0;
    endtask

    // Data read whose release cycle coincides with a producer push
    task automatic rd_push(input logic [7:0] b, input int unsigned n);
        bit acc;
        logic [7:0] e;
        e = (rx_m.size() != 0) ? rx_m[0] : 8'h00;
        repeat (n) rd_exp.push_back(e);
        A = io_addr(8'd1); nIORQ = 1'b0; nRD = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        nIORQ = 1'b1; nRD = 1'b1;
        acc = (rx_m.size() < DEPTH);
        chk("rx_ready_rdpush", 8'(rx_ready), 8'(acc));
        rx_data = b; rx_valid = 1'b1;
        @(posedge CLK); #1;
        rx_valid = 1'b0;
        if (rx_m.size() != 0) void'(rx_m.pop_front());
        else und_m = 1'b1;
        if (acc) rx_m.push_back(b);
    endtask

    // Illegal strobe pattern held n cycles; kind 0 = MREQ+IORQ+RD, 1 = MREQ+RD+WR
    task automatic illegal(input int unsigned kind, input int unsigned n);
        repeat (n) rd_exp.push_back(8'hFF);
        A = io_addr(8'd1);
        nMREQ = 1'b0; nRD = 1'b0;
        if (kind == 0) nIORQ = 1'b0; else nWR = 1'b0;
        repeat (n) @(posedge CLK);
        #1;
        nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
        @(posedge CLK); #1;
        err_m = 1'b1;
    endtask

    initial begin
        int unsigned n;
        logic [15:0] addr;
        logic [7:0]  b;
        nRESET = 1'b0; A = '0; WRITE_D = '0;
        nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge CLK);
        #1;
        chk("reset_bus_err", 8'(bus_err), 8'h00);
        chk("reset_tx_valid", 8'(tx_valid), 8'h00);
        chk("reset_rx_ready", 8'(rx_ready), 8'h01);
        chk("reset_read_d", READ_D, 8'hFF);
        nRESET = 1'b1;
        @(posedge CLK); #1;

        // Memory write, read back, aliased read
        mem_wr(16'h1234, 8'h5A, 3);
        mem_rd(16'h1234, 2);
        mem_rd(16'h0234, 1);
        chk("idle_read_d", READ_D, 8'hFF);

        // Single TX push under a long strobe
        io_wr(8'd1, 8'h41, 4);
        chk("tx_valid_one", 8'(tx_valid), 8'h01);
        chk("tx_data_one", tx_data, 8'h41);
        tx_pop();
        chk("tx_valid_drained", 8'(tx_valid), 8'h00);

        // RX data, underrun and clear
        rx_push(8'hC3);
        rx_push(8'h3C);
        io_rd(8'd0, 2);
        io_rd(8'd1, 2);
        io_rd(8'd1, 3);
        io_rd(8'd1, 1);
        io_rd(8'd0, 1);
        io_wr(8'd0, 8'h10, 1);
        io_rd(8'd0, 1);

        // TX overrun
        for (int i = 0; i < DEPTH; i++) io_wr(8'd1, 8'($urandom), $urandom_range(1, 3));
        io_wr(8'd1, 8'hEE, 1);
        io_rd(8'd0, 1);
        for (int i = 0; i <= DEPTH; i++) tx_pop();
        io_wr(8'd0, 8'h08, 2);
        io_rd(8'd0, 1);

        // RX full, simultaneous pop and push
        for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
        rx_push(8'hAA);
        io_rd(8'd1, 1);
        rd_push(8'h55, 2);
        rx_push(8'h66);
        rx_push(8'h77);
        for (int i = 0; i < DEPTH; i++) io_rd(8'd1, $urandom_range(1, 3));

        // Low region write with an aliased neighbour
        mem_wr(16'h1010, 8'hA5, 1);
        mem_wr(16'h0010, 8'h00, 2);
        chk("rom_bus_err", 8'(bus_err), 8'(err_m));
        mem_rd(16'h0010, 1);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            n = $urandom_range(1, 4);
            case ($urandom_range(0, 9))
                0, 1: mem_wr(16'($urandom), 8'($urandom), n);
                2, 3: if (keys.size() != 0) begin
                    addr = 16'(($urandom_range(0, 15) << MEM_AW) | keys[$urandom_range(0, keys.size() - 1)]);
                    mem_rd(addr, n);
                end
                4: io_wr(8'd1, 8'($urandom), n);
                5: io_rd(8'd1, n);
                6: io_rd(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(2, 255)), n);
                7: io_wr(($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(2, 255)), 8'($urandom), n);
                8: rx_push(8'($urandom));
                default: tx_pop();
            endcase
            if (i % 10 == 0) chk("rand_bus_err", 8'(bus_err), 8'(err_m));
        end
        io_rd(8'd0, 1);

        // Empty TX, then illegal patterns and a mid-access strobe change
        while (tx_m.size() != 0) tx_pop();
        rx_push(8'h9D);
        illegal(0, 2);
        chk("illegal_bus_err", 8'(bus_err), 8'h01);
        illegal(1, 1);
        rd_exp.push_back(status_m());
        A = io_addr(8'd0); nIORQ = 1'b0; nRD = 1'b0;
        @(posedge CLK); #1;
        A = io_addr(8'd1); WRITE_D = 8'hEE; nRD = 1'b1; nWR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nIORQ = 1'b1; nWR = 1'b1;
        @(posedge CLK); #1;
        io_rd(8'd0, 1);
        while (rx_m.size() > 1) io_rd(8'd1, 1);
        io_rd(8'd1, 1);

        // Reset during a data-port read
        rx_push(8'h77);
        rd_exp.push_back(rx_m[0]);
        rd_exp.push_back(rx_m[0]);
        io_wr(8'd1, 8'h12, 1);
        A = io_addr(8'd1); nIORQ = 1'b0; nRD = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        nRESET = 1'b0;
        nIORQ = 1'b1; nRD = 1'b1;
        rx_m.delete(); tx_m.delete();
        ovr_m = 1'b0; und_m = 1'b0; err_m = 1'b0;
        @(posedge CLK); #1;
        chk("mid_reset_bus_err", 8'(bus_err), 8'h00);
        chk("mid_reset_tx_valid", 8'(tx_valid), 8'h00);
        chk("mid_reset_rx_ready", 8'(rx_ready), 8'h01);
        nRESET = 1'b1;
        @(posedge CLK); #1;
        io_rd(8'd0, 1);
        io_rd(8'd1, 1);
        io_rd(8'd0, 1);

        @(posedge CLK); #1;
        chk("final_bus_err", 8'(bus_err), 8'(err_m));
        if (rd_exp.size() != 0) fail_now("read_queue_not_drained");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
